// File: rtl/wb_mem_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_FLUSH = 2'd3
  } arb_state_e;

  // One-hot grant encodings; bit x set means master x owns the bus.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Read data returned with a watchdog-synthesized ack.
  localparam logic [31:0] TIMEOUT_DAT = 32'h0000_0000;

  // Ceiling of the watchdog event counter.
  localparam logic [7:0] EVENT_COUNT_MAX = 8'hFF;

  // Grant vector for a given owner index (0 -> master 0, 1 -> master 1).
  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_watchdog.sv
// Ack-wait watchdog: counts stb-without-ack cycles and fires at the limit.
// Latency: fire is combinational in the limit cycle; event count updates one clock later.
// Backpressure: none; a real ack in the limit cycle suppresses the fire.
module wb_mem_arbiter_watchdog
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned              TIMEOUT_WIDTH  = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stb_i,
  input  logic       ack_i,
  output logic       fire_o,
  output logic [7:0] event_count_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_d;
  logic [7:0]               event_cnt_q;
  logic                     waiting;
  logic                     armed;

  // A zero limit disables the watchdog entirely.
  assign armed      = (TIMEOUT_CYCLES != CNT_ZERO);
  assign waiting    = stb_i & ~ack_i;
  // wait_cnt_q holds the number of earlier waiting cycles, so the current
  // cycle is number wait_cnt_q+1; fire when that equals the limit.
  assign wait_cnt_d = wait_cnt_q + CNT_ONE;
  assign fire_o     = armed & waiting & (wait_cnt_d == TIMEOUT_CYCLES);

  assign event_count_o = event_cnt_q;

  // Wait counter: advance while stalled, clear on ack, stb drop or fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (!waiting || fire_o) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Saturating count of watchdog events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      event_cnt_q <= 8'h00;
    end else if (fire_o && (event_cnt_q != EVENT_COUNT_MAX)) begin
      event_cnt_q <= event_cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master to one-slave Wishbone arbiter with ack watchdog.
// Latency: grant 1 clock after cyc in IDLE; bus signals routed combinationally once granted.
// Backpressure: a waiting master stalls until the owner drops cyc; one idle bus cycle between owners.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned              TIMEOUT_WIDTH  = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        m0_i_we,
  input  logic        m0_i_stb,
  input  logic        m0_i_cyc,
  input  logic [3:0]  m0_i_sel,
  input  logic [31:0] m0_i_adr,
  input  logic [31:0] m0_i_dat,
  output logic [31:0] m0_o_dat,
  output logic        m0_o_ack,
  output logic        m0_o_int,
  // master 1
  input  logic        m1_i_we,
  input  logic        m1_i_stb,
  input  logic        m1_i_cyc,
  input  logic [3:0]  m1_i_sel,
  input  logic [31:0] m1_i_adr,
  input  logic [31:0] m1_i_dat,
  output logic [31:0] m1_o_dat,
  output logic        m1_o_ack,
  output logic        m1_o_int,
  // memory slave
  output logic        mem_o_we,
  output logic        mem_o_stb,
  output logic        mem_o_cyc,
  output logic [3:0]  mem_o_sel,
  output logic [31:0] mem_o_adr,
  output logic [31:0] mem_o_dat,
  input  logic [31:0] mem_i_dat,
  input  logic        mem_i_ack,
  input  logic        mem_i_int,
  // status
  output logic [1:0]  o_grant,
  output logic        o_timeout,
  output logic [7:0]  o_timeout_count
);

  arb_state_e state_q;
  logic       last_owner_q;  // most recent owner; in FLUSH, the offending master
  logic [1:0] grant_q;
  logic       wd_fire;
  logic       flush_cyc;

  assign o_grant   = grant_q;
  assign o_timeout = wd_fire;

  // Interrupt is a plain fan-out, independent of ownership.
  assign m0_o_int = mem_i_int;
  assign m1_o_int = mem_i_int;

  // cyc of the master whose transfer was cut off by the watchdog.
  assign flush_cyc = last_owner_q ? m1_i_cyc : m0_i_cyc;

  wb_mem_arbiter_watchdog #(
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i         (clk),
    .rst_ni        (rst),
    .stb_i         (mem_o_stb),
    .ack_i         (mem_i_ack),
    .fire_o        (wd_fire),
    .event_count_o (o_timeout_count)
  );

  // Ownership FSM: round-robin on ties, release via IDLE, watchdog abort via FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
      grant_q      <= GRANT_NONE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_i_cyc && (!m1_i_cyc || last_owner_q)) begin
            state_q <= ARB_OWN0;
            grant_q <= grant_of(1'b0);
          end else if (m1_i_cyc) begin
            state_q <= ARB_OWN1;
            grant_q <= grant_of(1'b1);
          end
        end
        ARB_OWN0: begin
          if (wd_fire) begin
            state_q      <= ARB_FLUSH;
            last_owner_q <= 1'b0;
          end else if (!m0_i_cyc) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b0;
            grant_q      <= GRANT_NONE;
          end
        end
        ARB_OWN1: begin
          if (wd_fire) begin
            state_q      <= ARB_FLUSH;
            last_owner_q <= 1'b1;
          end else if (!m1_i_cyc) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
            grant_q      <= GRANT_NONE;
          end
        end
        default: begin
          if (!flush_cyc) begin
            state_q <= ARB_IDLE;
            grant_q <= GRANT_NONE;
          end
        end
      endcase
    end
  end

  // Request path: the owner drives the slave; IDLE and FLUSH present an idle bus.
  always_comb begin
    mem_o_we  = 1'b0;
    mem_o_stb = 1'b0;
    mem_o_cyc = 1'b0;
    mem_o_sel = 4'h0;
    mem_o_adr = 32'h0;
    mem_o_dat = 32'h0;
    case (state_q)
      ARB_OWN0: begin
        mem_o_we  = m0_i_we;
        mem_o_stb = m0_i_stb;
        mem_o_cyc = m0_i_cyc;
        mem_o_sel = m0_i_sel;
        mem_o_adr = m0_i_adr;
        mem_o_dat = m0_i_dat;
      end
      ARB_OWN1: begin
        mem_o_we  = m1_i_we;
        mem_o_stb = m1_i_stb;
        mem_o_cyc = m1_i_cyc;
        mem_o_sel = m1_i_sel;
        mem_o_adr = m1_i_adr;
        mem_o_dat = m1_i_dat;
      end
      default: ;
    endcase
  end

  // Response path: only the owner sees ack/data; a watchdog fire stands in for the missing ack.
  always_comb begin
    m0_o_ack = 1'b0;
    m0_o_dat = 32'h0;
    m1_o_ack = 1'b0;
    m1_o_dat = 32'h0;
    case (state_q)
      ARB_OWN0: begin
        m0_o_ack = mem_i_ack | wd_fire;
        m0_o_dat = wd_fire ? TIMEOUT_DAT : mem_i_dat;
      end
      ARB_OWN1: begin
        m1_o_ack = mem_i_ack | wd_fire;
        m1_o_dat = wd_fire ? TIMEOUT_DAT : mem_i_dat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with an 8-cycle watchdog limit.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later.
// Backpressure: slave ack is driven directly by the scenario tasks.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_i_we = 1'b0, m0_i_stb = 1'b0, m0_i_cyc = 1'b0;
  logic [3:0]  m0_i_sel = 4'h0;
  logic [31:0] m0_i_adr = 32'h0, m0_i_dat = 32'h0;
  logic [31:0] m0_o_dat;
  logic        m0_o_ack, m0_o_int;
  logic        m1_i_we = 1'b0, m1_i_stb = 1'b0, m1_i_cyc = 1'b0;
  logic [3:0]  m1_i_sel = 4'h0;
  logic [31:0] m1_i_adr = 32'h0, m1_i_dat = 32'h0;
  logic [31:0] m1_o_dat;
  logic        m1_o_ack, m1_o_int;
  logic        mem_o_we, mem_o_stb, mem_o_cyc;
  logic [3:0]  mem_o_sel;
  logic [31:0] mem_o_adr, mem_o_dat;
  logic [31:0] mem_i_dat = 32'h0;
  logic        mem_i_ack = 1'b0, mem_i_int = 1'b0;
  logic [1:0]  o_grant;
  logic        o_timeout;
  logic [7:0]  o_timeout_count;

  int n_cmp = 0;
  int n_bad = 0;

  wb_mem_arbiter #(.TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .rst(rst),
    .m0_i_we(m0_i_we), .m0_i_stb(m0_i_stb), .m0_i_cyc(m0_i_cyc), .m0_i_sel(m0_i_sel),
    .m0_i_adr(m0_i_adr), .m0_i_dat(m0_i_dat), .m0_o_dat(m0_o_dat), .m0_o_ack(m0_o_ack),
    .m0_o_int(m0_o_int),
    .m1_i_we(m1_i_we), .m1_i_stb(m1_i_stb), .m1_i_cyc(m1_i_cyc), .m1_i_sel(m1_i_sel),
    .m1_i_adr(m1_i_adr), .m1_i_dat(m1_i_dat), .m1_o_dat(m1_o_dat), .m1_o_ack(m1_o_ack),
    .m1_o_int(m1_o_int),
    .mem_o_we(mem_o_we), .mem_o_stb(mem_o_stb), .mem_o_cyc(mem_o_cyc), .mem_o_sel(mem_o_sel),
    .mem_o_adr(mem_o_adr), .mem_o_dat(mem_o_dat), .mem_i_dat(mem_i_dat), .mem_i_ack(mem_i_ack),
    .mem_i_int(mem_i_int),
    .o_grant(o_grant), .o_timeout(o_timeout), .o_timeout_count(o_timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish within 100000ns");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat);
    m0_i_cyc = cyc; m0_i_stb = stb; m0_i_we = we; m0_i_sel = 4'hF;
    m0_i_adr = adr; m0_i_dat = dat;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat);
    m1_i_cyc = cyc; m1_i_stb = stb; m1_i_we = we; m1_i_sel = 4'h3;
    m1_i_adr = adr; m1_i_dat = dat;
  endtask

  task automatic apply_reset();
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    drive_m1(0, 0, 0, 32'h0, 32'h0);
    mem_i_ack = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    mem_i_dat = 32'h5555_AAAA;
    mem_i_int = 1'b1;
    #1;
    n_cmp++; if (o_grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", o_grant); end
    n_cmp++; if ({mem_o_cyc, mem_o_stb, mem_o_we} !== 3'b000) begin n_bad++; $display("FAIL rst_mem_ctl: got %b want 000", {mem_o_cyc, mem_o_stb, mem_o_we}); end
    n_cmp++; if (m0_o_dat !== 32'h0 || m1_o_dat !== 32'h0) begin n_bad++; $display("FAIL rst_dat: got %h/%h want 0/0", m0_o_dat, m1_o_dat); end
    n_cmp++; if (o_timeout !== 1'b0 || o_timeout_count !== 8'h00) begin n_bad++; $display("FAIL rst_timeout: got %b/%h want 0/00", o_timeout, o_timeout_count); end
    n_cmp++; if (m0_o_int !== 1'b1 || m1_o_int !== 1'b1) begin n_bad++; $display("FAIL int_fanout_hi: got %b%b want 11", m0_o_int, m1_o_int); end
    mem_i_int = 1'b0;
    #1;
    n_cmp++; if (m0_o_int !== 1'b0 || m1_o_int !== 1'b0) begin n_bad++; $display("FAIL int_fanout_lo: got %b%b want 00", m0_o_int, m1_o_int); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_m0_single();
    drive_m0(1, 1, 1, 32'h10, 32'h0000_A5A5);
    #1;
    n_cmp++; if (o_grant !== 2'b00 || mem_o_cyc !== 1'b0) begin n_bad++; $display("FAIL single_pregrant: got %b/%b want 00/0", o_grant, mem_o_cyc); end
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", o_grant); end
    n_cmp++; if (mem_o_adr !== 32'h10 || mem_o_dat !== 32'h0000_A5A5 || mem_o_we !== 1'b1 || mem_o_sel !== 4'hF) begin n_bad++; $display("FAIL single_route: got adr %h dat %h we %b sel %h", mem_o_adr, mem_o_dat, mem_o_we, mem_o_sel); end
    n_cmp++; if (m0_o_ack !== 1'b0) begin n_bad++; $display("FAIL single_noack1: got %b want 0", m0_o_ack); end
    step();
    #1;
    n_cmp++; if (m0_o_ack !== 1'b0) begin n_bad++; $display("FAIL single_noack2: got %b want 0", m0_o_ack); end
    step();
    mem_i_ack = 1'b1;
    mem_i_dat = 32'h0000_1234;
    #1;
    n_cmp++; if (m0_o_ack !== 1'b1 || m0_o_dat !== 32'h0000_1234) begin n_bad++; $display("FAIL single_ack: got %b/%h want 1/00001234", m0_o_ack, m0_o_dat); end
    n_cmp++; if (m1_o_ack !== 1'b0 || m1_o_dat !== 32'h0) begin n_bad++; $display("FAIL single_m1_quiet: got %b/%h want 0/0", m1_o_ack, m1_o_dat); end
    step();
    mem_i_ack = 1'b0;
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b00) begin n_bad++; $display("FAIL single_release: got %b want 00", o_grant); end
  endtask

  task automatic test_tie();
    apply_reset();
    drive_m0(1, 1, 0, 32'h40, 32'h0);
    drive_m1(1, 1, 0, 32'h80, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b01 || mem_o_adr !== 32'h40) begin n_bad++; $display("FAIL tie_first: got %b/%h want 01/00000040", o_grant, mem_o_adr); end
    mem_i_ack = 1'b1;
    #1;
    n_cmp++; if (m0_o_ack !== 1'b1 || m1_o_ack !== 1'b0) begin n_bad++; $display("FAIL tie_ack_route: got %b%b want 10", m0_o_ack, m1_o_ack); end
    step();
    mem_i_ack = 1'b0;
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b00 || mem_o_cyc !== 1'b0) begin n_bad++; $display("FAIL tie_gap: got %b/%b want 00/0", o_grant, mem_o_cyc); end
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b10 || mem_o_adr !== 32'h80) begin n_bad++; $display("FAIL tie_second: got %b/%h want 10/00000080", o_grant, mem_o_adr); end
    drive_m1(0, 0, 0, 32'h0, 32'h0);
    step();
    drive_m0(1, 1, 0, 32'h44, 32'h0);
    drive_m1(1, 1, 0, 32'h84, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL tie_again: got %b want 01", o_grant); end
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    drive_m1(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_back_to_back();
    drive_m1(1, 1, 1, 32'h100, 32'hB000_0000);
    step();
    drive_m0(1, 1, 0, 32'h200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive_m1(1, 1, 1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k));
      mem_i_ack = 1'b1;
      mem_i_dat = 32'hD000_0000 + 32'(k);
      #1;
      n_cmp++; if (o_grant !== 2'b10 || mem_o_adr !== 32'h100 + 32'(4 * k)) begin n_bad++; $display("FAIL burst_hold_%0d: got %b/%h", k, o_grant, mem_o_adr); end
      n_cmp++; if (m1_o_ack !== 1'b1 || m1_o_dat !== 32'hD000_0000 + 32'(k) || m0_o_ack !== 1'b0) begin n_bad++; $display("FAIL burst_ack_%0d: got m1 %b/%h m0 %b", k, m1_o_ack, m1_o_dat, m0_o_ack); end
      step();
    end
    mem_i_ack = 1'b0;
    drive_m1(0, 0, 0, 32'h0, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b00) begin n_bad++; $display("FAIL burst_gap: got %b want 00", o_grant); end
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b01 || mem_o_adr !== 32'h200) begin n_bad++; $display("FAIL burst_handoff: got %b/%h want 01/00000200", o_grant, mem_o_adr); end
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_timeout();
    mem_i_dat = 32'hDEAD_BEEF;
    drive_m0(1, 1, 0, 32'h20, 32'h0);
    step();
    for (int i = 1; i < 8; i++) begin
      #1;
      n_cmp++; if (m0_o_ack !== 1'b0 || o_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_early_%0d: got ack %b to %b want 0/0", i, m0_o_ack, o_timeout); end
      step();
    end
    #1;
    n_cmp++; if (m0_o_ack !== 1'b1 || m0_o_dat !== 32'h0) begin n_bad++; $display("FAIL wd_synth_ack: got %b/%h want 1/00000000", m0_o_ack, m0_o_dat); end
    n_cmp++; if (o_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_pulse: got %b want 1", o_timeout); end
    step();
    mem_i_ack = 1'b1;
    #1;
    n_cmp++; if (mem_o_cyc !== 1'b0 || mem_o_stb !== 1'b0) begin n_bad++; $display("FAIL wd_flush_bus: got %b%b want 00", mem_o_cyc, mem_o_stb); end
    n_cmp++; if (m0_o_ack !== 1'b0 || o_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_flush_late_ack: got %b/%b want 0/0", m0_o_ack, o_timeout); end
    n_cmp++; if (o_timeout_count !== 8'd1) begin n_bad++; $display("FAIL wd_count1: got %0d want 1", o_timeout_count); end
    step();
    mem_i_ack = 1'b0;
    #1;
    n_cmp++; if (mem_o_cyc !== 1'b0) begin n_bad++; $display("FAIL wd_flush_hold: got %b want 0", mem_o_cyc); end
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b00) begin n_bad++; $display("FAIL wd_flush_exit: got %b want 00", o_grant); end
  endtask

  task automatic test_ack_at_expiry();
    drive_m0(1, 1, 0, 32'h24, 32'h0);
    step();
    repeat (7) step();
    mem_i_ack = 1'b1;
    mem_i_dat = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (m0_o_ack !== 1'b1 || m0_o_dat !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL race_ack: got %b/%h want 1/cafef00d", m0_o_ack, m0_o_dat); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL race_no_pulse: got %b want 0", o_timeout); end
    step();
    mem_i_ack = 1'b0;
    #1;
    n_cmp++; if (o_timeout_count !== 8'd1 || o_grant !== 2'b01 || mem_o_cyc !== 1'b1) begin n_bad++; $display("FAIL race_state: got cnt %0d grant %b cyc %b want 1/01/1", o_timeout_count, o_grant, mem_o_cyc); end
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      drive_m0(1, 1, 0, 32'h28, 32'h0);
      step();
      repeat (7) step();
      step();
      drive_m0(0, 0, 0, 32'h0, 32'h0);
      step();
    end
    #1;
    n_cmp++; if (o_timeout_count !== 8'hFF) begin n_bad++; $display("FAIL wd_saturate: got %h want ff", o_timeout_count); end
  endtask

  task automatic test_reset_mid();
    drive_m1(1, 1, 1, 32'h300, 32'h1111_2222);
    step();
    mem_i_ack = 1'b1;
    #1;
    n_cmp++; if (o_grant !== 2'b10 || mem_o_cyc !== 1'b1 || m1_o_ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %b/%b/%b want 10/1/1", o_grant, mem_o_cyc, m1_o_ack); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_o_cyc !== 1'b0 || mem_o_stb !== 1'b0 || o_grant !== 2'b00) begin n_bad++; $display("FAIL rstmid_drop: got cyc %b stb %b grant %b want 0/0/00", mem_o_cyc, mem_o_stb, o_grant); end
    n_cmp++; if (m0_o_ack !== 1'b0 || m1_o_ack !== 1'b0 || o_timeout_count !== 8'h00) begin n_bad++; $display("FAIL rstmid_ack: got %b%b cnt %h want 00/00", m0_o_ack, m1_o_ack, o_timeout_count); end
    mem_i_ack = 1'b0;
    drive_m0(1, 1, 0, 32'h400, 32'h0);
    step();
    rst = 1'b1;
    step();
    #1;
    n_cmp++; if (o_grant !== 2'b01 || mem_o_adr !== 32'h400) begin n_bad++; $display("FAIL rstmid_tie: got %b/%h want 01/00000400", o_grant, mem_o_adr); end
    drive_m0(0, 0, 0, 32'h0, 32'h0);
    drive_m1(0, 0, 0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    test_reset();
    test_m0_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_ack_at_expiry();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
